wb_write_arbiter: RTL

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

---
 rtl/wb_write_arbiter_pkg.sv | 16 +
 rtl/wb_result_fifo.sv | 59 +++++
 rtl/wb_write_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared CPU definitions: register-file geometry and the writeback request payload.
// Also used by the register file and the hazard unit.
package wb_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer holding long-latency results until a writeback slot is free.
// Push while full is accepted only when a pop happens in the same cycle.
module wb_result_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  wb_req_t          wdata_i,
  output wb_req_t          rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback port arbiter: pipeline writes always win, long-latency results are buffered
// and drained in idle slots; tracks outstanding long-latency destinations and starvation.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  pipe_wr_en,
  input  logic [REG_ADDR_W-1:0] pipe_wr_reg,
  input  logic [DATA_W-1:0]     pipe_wr_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_reg,
  input  logic [DATA_W-1:0]     lu_data,
  input  logic                  lu_issue,
  input  logic [REG_ADDR_W-1:0] lu_issue_reg,
  output logic                  MEM_WB_RegWrite,
  output logic [REG_ADDR_W-1:0] MEM_WB_WriteRegister,
  output logic [DATA_W-1:0]     WB_WriteData,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  stall_req
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  wb_req_t               fifo_head, lu_req, win;
  logic                  bypass, win_valid;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  stall_q, stall_d;

  assign lu_req = '{rd: lu_reg, data: lu_data};

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (lu_req),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Source selection: pipeline, else FIFO head, else bypass of a fresh lu result
  always_comb begin
    fifo_pop  = !pipe_wr_en && !fifo_empty;
    bypass    = !pipe_wr_en && fifo_empty && lu_valid;
    lu_ready  = !fifo_full || fifo_pop;
    fifo_push = lu_valid && lu_ready && !bypass;
    win_valid = pipe_wr_en || fifo_pop || bypass;
    win       = '{rd: pipe_wr_reg, data: pipe_wr_data};
    if (!pipe_wr_en) win = fifo_empty ? lu_req : fifo_head;
  end

  always_comb begin
    we_d   = win_valid && (win.rd != REG_ZERO);
    addr_d = we_d ? win.rd   : addr_q;
    data_d = we_d ? win.data : data_q;

    // Clear on the write currently presented; a same-cycle issue re-sets the bit
    pending_d = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      pending_d[r] = (pending_q[r] && !(we_q && addr_q == REG_ADDR_W'(r)))
                   || (lu_issue && lu_issue_reg == REG_ADDR_W'(r));
    end

    starve_d = '0;
    if (fifo_cnt != '0 && pipe_wr_en) begin
      starve_d = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q : starve_q + STV_W'(1);
    end
    stall_d = (starve_d == STV_W'(STARVE_LIMIT));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      pending_q <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
    end else begin
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
    end
  end

  assign MEM_WB_RegWrite      = we_q;
  assign MEM_WB_WriteRegister = addr_q;
  assign WB_WriteData         = data_q;
  assign pending              = pending_q;
  assign stall_req            = stall_q;

endmodule
